// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//
// Parallel-to-serial stage feeding the 1-bit `number` input of the
// sequence-detector FSM.
//
// The serializer accepts a WIDTH-bit word over a valid/ready handshake. It
// then shifts the word out one bit per clock, and bit_valid qualifies each
// bit. When the serializer is idle, `number` is held low. This keeps the
// downstream detector parked in its initial state between words.
//
// Handshake: a word is accepted on a rising edge where load_valid and
// load_ready are both high. load_ready does not depend on load_valid. The
// producer may raise or drop load_valid at any time. Nothing happens unless
// the valid and ready signals coincide at an edge.
//
// Parameters:
//   WIDTH      bits per word (2..32)
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//   GAP        idle cycles forced between words (0..15)
//
// Optional build macro:
//   SERIALIZER_PARITY_EN  appends one even-parity bit cycle to every word
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   load_valid producer offers load_data
//   load_data  word to serialize
//   load_ready serializer can accept a word this cycle
//   number     serial data bit to the detector
//   bit_valid  number carries a data bit this cycle
//   busy       state is not IDLE
//   done       one-cycle pulse during the final bit of a word
//   dbg_state  current FSM state encoding (observation only)
//
// Every output is a register loaded from the next-state values, so the
// outputs are a pure function of registered state. No combinational path
// runs from the load_* inputs to the outputs.
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             number,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

`ifdef SERIALIZER_PARITY_EN
    // The parity bit rides at the tail of a widened shift register.
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int             CW       = $clog2(NB);
    localparam logic [CW-1:0]  LAST     = CW'(NB - 1);
    localparam logic [3:0]     GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t          state;
    logic [NB-1:0]   shreg;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      gap_cnt;

    state_t          nxt_state;
    logic [NB-1:0]   nxt_shreg;
    logic [CW-1:0]   nxt_bit_cnt;
    logic [3:0]      nxt_gap_cnt;
    logic [NB-1:0]   load_word;
    logic            accept;
    logic            nxt_shift;
    logic            nxt_number;
    logic            nxt_done;
    logic            nxt_ready;

    assign dbg_state = state;
    assign accept    = load_valid & load_ready;

    // The load image places the first bit to send at the output end of the
    // register. In a parity build, the parity bit sits at the far end.
    always_comb begin
        load_word = '0;
`ifdef SERIALIZER_PARITY_EN
        if (MSB_FIRST != 0)
            load_word = {load_data, ^load_data};
        else
            load_word = {^load_data, load_data};
`else
        load_word = load_data;
`endif
    end

    always_comb begin
        nxt_state   = state;
        nxt_shreg   = shreg;
        nxt_bit_cnt = bit_cnt;
        nxt_gap_cnt = gap_cnt;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nxt_state   = ST_SHIFT;
                    nxt_shreg   = load_word;
                    nxt_bit_cnt = '0;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt == LAST) begin
                    if (GAP == 0) begin
                        // With no gap, an accept on the last bit continues
                        // straight into the next word with no bubble.
                        if (accept) begin
                            nxt_state   = ST_SHIFT;
                            nxt_shreg   = load_word;
                            nxt_bit_cnt = '0;
                        end else begin
                            nxt_state   = ST_IDLE;
                            nxt_shreg   = '0;
                            nxt_bit_cnt = '0;
                        end
                    end else begin
                        nxt_state   = ST_GAP;
                        nxt_shreg   = '0;
                        nxt_bit_cnt = '0;
                        nxt_gap_cnt = '0;
                    end
                end else begin
                    if (MSB_FIRST != 0)
                        nxt_shreg = {shreg[NB-2:0], 1'b0};
                    else
                        nxt_shreg = {1'b0, shreg[NB-1:1]};
                    nxt_bit_cnt = CW'(bit_cnt + 1'b1);
                end
            end

            ST_GAP: begin
                if (GAP == 0 || gap_cnt == GAP_LAST) begin
                    nxt_state   = ST_IDLE;
                    nxt_gap_cnt = '0;
                end else begin
                    nxt_gap_cnt = gap_cnt + 4'd1;
                end
            end

            default: begin
                // An unused encoding falls back to a clean idle.
                nxt_state   = ST_IDLE;
                nxt_shreg   = '0;
                nxt_bit_cnt = '0;
                nxt_gap_cnt = '0;
            end
        endcase
    end

    // The output registers are loaded from the next-state view. They
    // therefore always match the state register they accompany.
    always_comb begin
        nxt_shift  = (nxt_state == ST_SHIFT);
        nxt_number = 1'b0;
        if (nxt_shift)
            nxt_number = (MSB_FIRST != 0) ? nxt_shreg[NB-1] : nxt_shreg[0];
        nxt_done   = nxt_shift && (nxt_bit_cnt == LAST);
        nxt_ready  = (nxt_state == ST_IDLE) ||
                     (nxt_shift && (nxt_bit_cnt == LAST) && (GAP == 0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            number     <= 1'b0;
            bit_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            state      <= nxt_state;
            shreg      <= nxt_shreg;
            bit_cnt    <= nxt_bit_cnt;
            gap_cnt    <= nxt_gap_cnt;
            number     <= nxt_number;
            bit_valid  <= nxt_shift;
            busy       <= (nxt_state != ST_IDLE);
            done       <= nxt_done;
            load_ready <= nxt_ready;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// ---------------------------------------------------------------------------
// tb_bit_serializer
//
// dut0: WIDTH=8, MSB_FIRST=1, GAP=0.
// dut1: WIDTH=8, MSB_FIRST=0, GAP=3.
//
// An entry of {number, done} is queued for every bit a word should produce.
// A negedge monitor pops one entry per bit_valid cycle. Each scenario task
// also checks the cycle-level handshake and status outputs inline.
// ---------------------------------------------------------------------------
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = 8 + PAR;

    logic       clk;
    logic       rst_n;

    logic       v0, r0, n0, bv0, b0, dn0;
    logic [7:0] d0;
    logic [1:0] st0;
    logic       v1, r1, n1, bv1, b1, dn1;
    logic [7:0] d1;
    logic [1:0] st1;

    int checks = 0;
    int errors = 0;

    logic [1:0] exp0_q[$];
    logic [1:0] exp1_q[$];
    logic [1:0] e0, e1;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(0)) dut0 (
        .clk(clk), .reset(rst_n), .load_valid(v0), .load_data(d0),
        .load_ready(r0), .number(n0), .bit_valid(bv0), .busy(b0),
        .done(dn0), .dbg_state(st0)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(3)) dut1 (
        .clk(clk), .reset(rst_n), .load_valid(v1), .load_data(d1),
        .load_ready(r1), .number(n1), .bit_valid(bv1), .busy(b1),
        .done(dn1), .dbg_state(st1)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            exp0_q.push_back({w[7-i], (PAR == 0 && i == 7)});
        if (PAR != 0)
            exp0_q.push_back({^w, 1'b1});
    endtask

    task automatic push1(input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            exp1_q.push_back({w[i], (PAR == 0 && i == 7)});
        if (PAR != 0)
            exp1_q.push_back({^w, 1'b1});
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst_n && bv0) begin
            checks++;
            if (exp0_q.size() == 0) begin
                errors++;
                $display("FAIL sb0_underflow: bit_valid=1 with no expected bit");
            end else begin
                e0 = exp0_q.pop_front();
                if ({n0, dn0} !== e0) begin
                    errors++;
                    $display("FAIL sb0_bit: {number,done}=%b expected %b at %0t", {n0, dn0}, e0, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bv1) begin
            checks++;
            if (exp1_q.size() == 0) begin
                errors++;
                $display("FAIL sb1_underflow: bit_valid=1 with no expected bit");
            end else begin
                e1 = exp1_q.pop_front();
                if ({n1, dn1} !== e1) begin
                    errors++;
                    $display("FAIL sb1_bit: {number,done}=%b expected %b at %0t", {n1, dn1}, e1, $time);
                end
            end
        end
    end

    // One complete word on dut0 with an idle check afterwards.
    task automatic run_word0(input logic [7:0] w, input string tag);
        checks++;
        if (r0 !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_before: load_ready=%b expected 1", tag, r0);
        end
        v0 = 1'b1;
        d0 = w;
        push0(w);
        tick();
        v0 = 1'b0;
        for (int k = 1; k <= NB; k++) begin
            checks++;
            if ({bv0, b0, r0, dn0} !== {1'b1, 1'b1, (k == NB), (k == NB)}) begin
                errors++;
                $display("FAIL %s_cycle%0d: {bv,busy,ready,done}=%b expected %b", tag, k,
                         {bv0, b0, r0, dn0}, {1'b1, 1'b1, (k == NB), (k == NB)});
            end
            d0 = 8'($urandom_range(0, 255));
            tick();
        end
        checks++;
        if ({n0, bv0, b0, r0, dn0} !== 5'b00010 || exp0_q.size() != 0) begin
            errors++;
            $display("FAIL %s_idle_after: {n,bv,busy,ready,done}=%b expected 00010, queue=%0d expected 0",
                     tag, {n0, bv0, b0, r0, dn0}, exp0_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        v0 = 1'b0; d0 = '0;
        v1 = 1'b0; d1 = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({n0, bv0, b0, dn0, r0} !== 5'b00001) begin
                errors++;
                $display("FAIL reset_hold%0d: {n,bv,busy,done,ready}=%b expected 00001", i, {n0, bv0, b0, dn0, r0});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({n0, bv0, b0, dn0, r0} !== 5'b00001 || {n1, bv1, b1, dn1, r1} !== 5'b00001 || st0 !== 2'd0) begin
                errors++;
                $display("FAIL idle%0d: dut0=%b dut1=%b state=%0d expected 00001/00001/0", i,
                         {n0, bv0, b0, dn0, r0}, {n1, bv1, b1, dn1, r1}, st0);
            end
        end
    endtask

    task automatic test_single_word();
        run_word0(8'hB2, "single");
    endtask

    task automatic test_back_to_back();
        v0 = 1'b1;
        d0 = 8'hB2;
        push0(8'hB2);
        push0(8'h0F);
        tick();
        d0 = 8'h0F;
        for (int k = 1; k <= 2 * NB; k++) begin
            checks++;
            if ({bv0, r0, dn0} !== {1'b1, (k == NB || k == 2 * NB), (k == NB || k == 2 * NB)}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: {bv,ready,done}=%b expected %b", k, {bv0, r0, dn0},
                         {1'b1, (k == NB || k == 2 * NB), (k == NB || k == 2 * NB)});
            end
            tick();
            if (k == NB) begin
                v0 = 1'b0;
                d0 = 8'($urandom_range(0, 255));
            end
        end
        checks++;
        if ({bv0, b0, r0} !== 3'b001 || exp0_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_idle_after: {bv,busy,ready}=%b expected 001, queue=%0d expected 0",
                     {bv0, b0, r0}, exp0_q.size());
        end
    endtask

    task automatic test_lsb_gap();
        v1 = 1'b1;
        d1 = 8'h01;
        push1(8'h01);
        tick();
        d1 = 8'h80;
        for (int k = 1; k <= NB; k++) begin
            checks++;
            if ({bv1, b1, r1, dn1} !== {1'b1, 1'b1, 1'b0, (k == NB)}) begin
                errors++;
                $display("FAIL gap_shift%0d: {bv,busy,ready,done}=%b expected %b", k,
                         {bv1, b1, r1, dn1}, {1'b1, 1'b1, 1'b0, (k == NB)});
            end
            tick();
        end
        for (int g = 0; g < 3; g++) begin
            checks++;
            if ({n1, bv1, b1, r1, dn1} !== 5'b00100) begin
                errors++;
                $display("FAIL gap_idle%0d: {n,bv,busy,ready,done}=%b expected 00100", g, {n1, bv1, b1, r1, dn1});
            end
            tick();
        end
        checks++;
        if ({b1, r1} !== 2'b01) begin
            errors++;
            $display("FAIL gap_ready_rise: {busy,ready}=%b expected 01", {b1, r1});
        end
        push1(8'h80);
        tick();
        v1 = 1'b0;
        for (int k = 0; k < NB + 3; k++)
            tick();
        checks++;
        if ({bv1, b1, r1} !== 3'b001 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL gap_second_word: {bv,busy,ready}=%b expected 001, queue=%0d expected 0",
                     {bv1, b1, r1}, exp1_q.size());
        end
    endtask

    task automatic test_async_reset();
        v0 = 1'b1;
        d0 = 8'hFF;
        push0(8'hFF);
        tick();
        v0 = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({n0, bv0, b0, dn0, r0} !== 5'b00001) begin
            errors++;
            $display("FAIL async_reset_drop: {n,bv,busy,done,ready}=%b expected 00001", {n0, bv0, b0, dn0, r0});
        end
        exp0_q.delete();
        tick();
        checks++;
        if ({n0, bv0, dn0, r0} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_held: {n,bv,done,ready}=%b expected 0001", {n0, bv0, dn0, r0});
        end
        rst_n = 1'b1;
        tick();
        run_word0(8'h5A, "post_reset");
    endtask

    task automatic test_parity();
        run_word0(8'h07, "parity07");
        run_word0(8'h03, "parity03");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_gap();
        test_async_reset();
        test_parity();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage that sits directly upstream of the sequence-detector FSM and drives its 1-bit `number` input.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock, with a qualifying `bit_valid` strobe.
- Drives `number` low whenever idle, so the downstream detector is parked in its initial state between words.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- GAP, 0: idle cycles forced between words; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  producer offers load_data this cycle.
- load_data  in  WIDTH  word to serialize.
- load_ready  out  1  serializer can accept a word this cycle.
- number  out  1  serial data bit to the detector FSM.
- bit_valid  out  1  number carries a data bit this cycle.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse during the final bit of a word.

Behaviour:
- States: IDLE, SHIFT, GAP, held in a 2-bit state register. Also kept: a WIDTH-bit shift register, a bit counter of $clog2(WIDTH) bits, and a 4-bit gap counter.
- Reset (reset=0, asynchronous): state=IDLE and all registers cleared. Outputs: number=0, bit_valid=0, busy=0, done=0, load_ready=1. Reset mid-word aborts the word with no done pulse, and the word is lost.
- Outputs depend only on registered state (Moore). No combinational path from load_valid or load_data to number or bit_valid.
- Accept: load_valid & load_ready sampled high at a rising edge. On that edge, load_data goes into the shift register, the bit counter is set to 0 and state becomes SHIFT.
- Latency: the first bit appears on number in the cycle after the accept edge. A word therefore occupies exactly WIDTH consecutive cycles.
- IDLE: load_ready=1, number=0, bit_valid=0, busy=0.
- SHIFT: bit_valid=1, busy=1.
  - number = shift register bit WIDTH-1 when MSB_FIRST=1, else bit 0.
  - Each edge shifts the register toward the output end, zero-filling, and increments the bit counter.
- Last bit (bit counter = WIDTH-1):
  - done=1 for this cycle only.
  - If GAP=0, load_ready=1 in this cycle. An accept here loads the next word and stays in SHIFT, giving back-to-back words with no bubble; with no accept, next state is IDLE.
  - If GAP>0, load_ready=0 and next state is GAP with the gap counter cleared.
- GAP: number=0, bit_valid=0, busy=1, load_ready=0. The gap counter increments each cycle; at GAP-1 the next state is IDLE. Exactly GAP idle cycles occur before load_ready rises again.
- In every SHIFT cycle except the last-bit case above, load_ready=0. load_data changes while load_ready=0 are ignored.
- load_valid may drop without an accept; no state change results.
- Unused or illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - Each word is followed by one extra SHIFT cycle carrying the even-parity bit (XOR of all WIDTH data bits, captured at the accept edge), with bit_valid=1.
  - A word occupies WIDTH+1 cycles, and done and the GAP=0 load_ready window move to the parity cycle.
  - The bit counter widens to $clog2(WIDTH+1).
- Undefined: no parity cycle, and no parity logic or registers are synthesized.

Test Plan:
1. Reset then idle: reset=0 for 3 cycles, then release with load_valid=0 for 10 cycles -> number=0, bit_valid=0, busy=0, done=0, load_ready=1 throughout.
2. Single word, WIDTH=8, MSB_FIRST=1, GAP=0: accept 8'hB2 at edge E0 -> cycles 1..8 give number 1,0,1,1,0,0,1,0 with bit_valid=1; done=1 only in cycle 8; load_ready=0 in cycles 1..7; IDLE from cycle 9.
3. Back-to-back, GAP=0: 8'hB2, then 8'h0F held valid -> second word accepted on the cycle-8 edge; cycles 9..16 give 0,0,0,0,1,1,1,1; bit_valid never drops between words.
4. LSB-first with gap, MSB_FIRST=0, GAP=3: 8'h01 accepted, next word held valid -> cycles 1..8 give 1,0,0,0,0,0,0,0; cycles 9..11 give number=0, bit_valid=0, load_ready=0; load_ready=1 in cycle 12.
5. Async reset mid-word: reset driven low between edges in cycle 4 of 8'hFF -> number and bit_valid fall immediately, no done pulse; after release, load_ready=1 and the next word serializes cleanly.
6. Parity (SERIALIZER_PARITY_EN defined, WIDTH=8): word 8'h07 -> 8 data bits then parity bit 1 in cycle 9, with done in cycle 9. Word 8'h03 -> parity bit 0.
